// File: rtl/i2c_byte_phy.sv
// Byte-level open-drain I2C master: turns START/STOP/WRITE/READ commands into
// quarter-bit SCL/SDA pull-down enables, with clock-stretch and ACK handling.
module i2c_byte_phy #(
    parameter int unsigned DW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       stb,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    output logic [7:0] data_out,
    output logic       ack_out,
    output logic       ready,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam logic [1:0]    CMD_START = 2'd0;
    localparam logic [1:0]    CMD_STOP  = 2'd1;
    localparam logic [1:0]    CMD_READ  = 2'd3;
    localparam logic [DW-1:0] QCNT_MAX  = {DW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_BIT,
        S_ACKBIT
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic          rd_q, rd_d;
    logic [7:0]    tx_q, tx_d;
    logic          ackin_q, ackin_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          ack_out_q, ack_out_d;
    logic          ready_q, ready_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick_c;
    logic          scl_edge_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            quarter_q  <= 2'd0;
            bit_q      <= 3'd0;
            rd_q       <= 1'b0;
            tx_q       <= 8'h00;
            ackin_q    <= 1'b0;
            rx_q       <= 8'h00;
            data_out_q <= 8'h00;
            ack_out_q  <= 1'b0;
            ready_q    <= 1'b1;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            ackin_q    <= ackin_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            ack_out_q  <= ack_out_d;
            ready_q    <= ready_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        rd_d       = rd_q;
        tx_d       = tx_q;
        ackin_d    = ackin_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        ack_out_d  = ack_out_q;
        ready_d    = ready_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        tick_c     = 1'b0;
        scl_edge_c = 1'b0;

        if (state_q == S_IDLE) begin
            qcnt_d = '0;
            if (ready_q && stb) begin
                rd_d      = (cmd == CMD_READ);
                tx_d      = data_in;
                ackin_d   = ack_in;
                rx_d      = 8'h00;
                bit_d     = 3'd7;
                quarter_d = 2'd0;
                ready_d   = 1'b0;
                if (cmd == CMD_START)     state_d = S_START;
                else if (cmd == CMD_STOP) state_d = S_STOP;
                else                      state_d = S_BIT;
            end
        end else if (quarter_q == 2'd1 && !scl_i) begin
            // SCL released but still held low by a slave: stall the quarter
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + DW'(1);
            tick_c = (qcnt_q == QCNT_MAX);
        end

        if (tick_c) begin
            quarter_d = quarter_q + 2'd1;
            if (quarter_q == 2'd2) begin
                if (state_q == S_BIT && rd_q)     rx_d      = {rx_q[6:0], sda_i};
                if (state_q == S_ACKBIT && !rd_q) ack_out_d = sda_i;
            end
            if (quarter_q == 2'd3) begin
                if (state_q == S_BIT && bit_q != 3'd0) begin
                    bit_d = bit_q - 3'd1;
                end else if (state_q == S_BIT) begin
                    state_d = S_ACKBIT;
                end else begin
                    if (state_q == S_ACKBIT && rd_q) data_out_d = rx_q;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
        end

        // Pad enables follow the upcoming state/quarter; idle holds the last levels
        scl_edge_c = (quarter_d == 2'd0) || (quarter_d == 2'd3);
        case (state_d)
            S_START: begin
                scl_oe_d = scl_edge_c;
                sda_oe_d = quarter_d[1];
            end
            S_STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = (quarter_d != 2'd3);
            end
            S_BIT: begin
                scl_oe_d = scl_edge_c;
                sda_oe_d = rd_d ? 1'b0 : ~tx_d[bit_d];
            end
            S_ACKBIT: begin
                scl_oe_d = scl_edge_c;
                sda_oe_d = rd_d ? ~ackin_d : 1'b0;
            end
            default: begin
                scl_oe_d = scl_oe_q;
                sda_oe_d = sda_oe_q;
            end
        endcase
    end

    assign data_out = data_out_q;
    assign ack_out  = ack_out_q;
    assign ready    = ready_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;

endmodule
